// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Brief    : Shared widths, note-event layout and dispatcher state encoding.
// Revision : 1.0
// ============================================================================
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int EVT_W  = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } note_evt_t;

    // Dispatcher state is a pure function of FIFO occupancy.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module   : dffr / dffre
// Brief    : Synchronous-reset register, plain and with load enable.
// Revision : 1.0
// ============================================================================
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_fifo.sv
`default_nettype none
// ============================================================================
// Module   : note_fifo
// Brief    : Single-clock FIFO with push/pop/flush; head is always on o_data.
// Revision : 1.0
// ============================================================================
module note_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [c_PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [c_CNT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0]   w_mem [DEPTH];
    logic               w_write;

    assign w_write = i_push & ~i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    dffr #(.WIDTH(c_PTR_W)) u_wr_ptr (.clk(clk), .rst(rst), .i_d(wr_ptr_d), .o_q(wr_ptr_q));
    dffr #(.WIDTH(c_PTR_W)) u_rd_ptr (.clk(clk), .rst(rst), .i_d(rd_ptr_d), .o_q(rd_ptr_q));
    dffr #(.WIDTH(c_CNT_W)) u_count  (.clk(clk), .rst(rst), .i_d(count_d),  .o_q(count_q));

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            dffre #(.WIDTH(WIDTH)) u_mem (
                .clk  (clk),
                .rst  (rst),
                .i_en (w_write && (wr_ptr_q == c_PTR_W'(i))),
                .i_d  (i_data),
                .o_q  (w_mem[i])
            );
        end
    endgenerate

    assign o_data  = w_mem[rd_ptr_q];
    assign o_full  = (count_q == c_CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/note_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : note_dispatcher
// Brief    : Buffers note events and hands each to the lowest-index free player.
// Revision : 1.0
// ============================================================================
module note_dispatcher #(
    parameter int NUM_PLAYERS = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int NOTE_W      = music_pkg::NOTE_W,
    parameter int DUR_W       = music_pkg::DUR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [NOTE_W-1:0]      in_note,
    input  logic [DUR_W-1:0]       in_duration,
    output logic                   in_ready,
    input  logic [NUM_PLAYERS-1:0] note_done,
    output logic [NUM_PLAYERS-1:0] player_new_note,
    output logic [NOTE_W-1:0]      player_note,
    output logic [DUR_W-1:0]       player_duration,
    output logic [NUM_PLAYERS-1:0] busy,
    output logic                   overflow
);

    import music_pkg::*;

    localparam int c_EVT_W = NOTE_W + DUR_W;

    logic [NUM_PLAYERS-1:0] busy_d, busy_q;
    logic [NUM_PLAYERS-1:0] new_note_d, new_note_q;
    logic [NOTE_W-1:0]      note_d, note_q;
    logic [DUR_W-1:0]       dur_d, dur_q;
    logic                   overflow_d, overflow_q;

    logic [c_EVT_W-1:0]     w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_dispatch;
    logic [NUM_PLAYERS-1:0] w_free_onehot;
    disp_state_e            w_state;

    note_fifo #(
        .WIDTH (c_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_dispatch),
        .i_flush (flush),
        .i_data  ({in_note, in_duration}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_state  = w_empty ? ST_IDLE : ST_PENDING;
    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full & ~flush;

    // Adding one to the busy vector ripples through the low run of ones,
    // leaving exactly the lowest clear bit set after masking with ~busy.
    assign w_free_onehot = ~busy_q & (busy_q + NUM_PLAYERS'(1));
    assign w_dispatch    = play & (w_state == ST_PENDING) & ~flush & ~(&busy_q);

    always_comb begin
        busy_d     = busy_q & ~note_done;
        new_note_d = '0;
        note_d     = note_q;
        dur_d      = dur_q;
        overflow_d = overflow_q | (in_valid & w_full & ~flush);
        if (w_dispatch) begin
            busy_d     = busy_d | w_free_onehot;
            new_note_d = w_free_onehot;
            note_d     = w_head[c_EVT_W-1:DUR_W];
            dur_d      = w_head[DUR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            new_note_q <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            new_note_q <= new_note_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy            = busy_q;
    assign player_new_note = new_note_q;
    assign player_note     = note_q;
    assign player_duration = dur_q;
    assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_note_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_dispatcher
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_note_dispatcher;

    localparam int NP    = 3;
    localparam int DEPTH = 4;
    localparam int NW    = 6;
    localparam int DW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          play = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [NW-1:0] in_note = '0;
    logic [DW-1:0] in_duration = '0;
    logic          in_ready;
    logic [NP-1:0] note_done = '0;
    logic [NP-1:0] player_new_note;
    logic [NW-1:0] player_note;
    logic [DW-1:0] player_duration;
    logic [NP-1:0] busy;
    logic          overflow;

    int tests  = 0;
    int failed = 0;

    note_dispatcher #(
        .NUM_PLAYERS (NP),
        .FIFO_DEPTH  (DEPTH),
        .NOTE_W      (NW),
        .DUR_W       (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .play            (play),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_note         (in_note),
        .in_duration     (in_duration),
        .in_ready        (in_ready),
        .note_done       (note_done),
        .player_new_note (player_new_note),
        .player_note     (player_note),
        .player_duration (player_duration),
        .busy            (busy),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending events and a per-player busy list.
    typedef struct packed {
        logic [NW-1:0] n;
        logic [DW-1:0] d;
    } evt_t;

    evt_t          m_q[$];
    logic [NP-1:0] m_busy;
    logic [NP-1:0] m_pnn;
    logic [NW-1:0] m_note;
    logic [DW-1:0] m_dur;
    logic          m_ovf;

    function automatic void model_step();
        bit   full;
        int   tgt;
        evt_t e;
        if (reset) begin
            m_q.delete();
            m_busy = '0;
            m_pnn  = '0;
            m_note = '0;
            m_dur  = '0;
            m_ovf  = 1'b0;
            return;
        end
        full = (m_q.size() >= DEPTH);
        tgt  = -1;
        for (int i = 0; i < NP; i++) begin
            if (!m_busy[i] && tgt < 0) tgt = i;
        end
        for (int i = 0; i < NP; i++) begin
            if (note_done[i]) m_busy[i] = 1'b0;
        end
        m_pnn = '0;
        if (play && m_q.size() > 0 && !flush && tgt >= 0) begin
            e = m_q.pop_front();
            m_busy[tgt] = 1'b1;
            m_pnn[tgt]  = 1'b1;
            m_note      = e.n;
            m_dur       = e.d;
        end
        if (flush) begin
            m_q.delete();
        end else if (in_valid) begin
            if (!full) begin
                e.n = in_note;
                e.d = in_duration;
                m_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        play      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        note_done = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (busy !== 3'b000) begin failed++; $display("FAIL reset_busy: got %b want 000", busy); end
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL reset_pnn: got %b want 000", player_new_note); end
        tests++; if (player_note !== 6'd0) begin failed++; $display("FAIL reset_note: got %0d want 0", player_note); end
        tests++; if (player_duration !== 6'd0) begin failed++; $display("FAIL reset_dur: got %0d want 0", player_duration); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        play = 1'b1; in_valid = 1'b1; in_note = 6'd20; in_duration = 6'd8;
        tick();
        in_valid = 1'b0;
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL single_nobypass: got %b want 000", player_new_note); end
        tick();
        tests++; if (player_new_note !== 3'b001) begin failed++; $display("FAIL single_pnn: got %b want 001", player_new_note); end
        tests++; if (player_note !== 6'd20) begin failed++; $display("FAIL single_note: got %0d want 20", player_note); end
        tests++; if (player_duration !== 6'd8) begin failed++; $display("FAIL single_dur: got %0d want 8", player_duration); end
        tests++; if (busy !== 3'b001) begin failed++; $display("FAIL single_busy: got %b want 001", busy); end
        tick();
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL single_pulse_len: got %b want 000", player_new_note); end
        tests++; if (player_note !== 6'd20) begin failed++; $display("FAIL single_hold: got %0d want 20", player_note); end
        note_done = 3'b001;
        tick();
        note_done = '0;
        tests++; if (busy !== 3'b000) begin failed++; $display("FAIL single_done: got %b want 000", busy); end
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] exp_pnn [4];
        exp_pnn[0] = 3'b000; exp_pnn[1] = 3'b001; exp_pnn[2] = 3'b010; exp_pnn[3] = 3'b100;
        do_reset();
        play = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_note = 6'(10 + k); in_duration = 6'(k + 1);
            tick();
            tests++; if (player_new_note !== exp_pnn[k]) begin failed++; $display("FAIL b2b_pnn%0d: got %b want %b", k, player_new_note, exp_pnn[k]); end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL b2b_wait: got %b want 000", player_new_note); end
        tests++; if (busy !== 3'b111) begin failed++; $display("FAIL b2b_allbusy: got %b want 111", busy); end
        note_done = 3'b010;
        tick();
        note_done = '0;
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL b2b_free_edge: got %b want 000", player_new_note); end
        tests++; if (busy !== 3'b101) begin failed++; $display("FAIL b2b_freed: got %b want 101", busy); end
        tick();
        tests++; if (player_new_note !== 3'b010) begin failed++; $display("FAIL b2b_fourth: got %b want 010", player_new_note); end
        tests++; if (player_note !== 6'd13) begin failed++; $display("FAIL b2b_fourth_note: got %0d want 13", player_note); end
        tests++; if (player_duration !== 6'd4) begin failed++; $display("FAIL b2b_fourth_dur: got %0d want 4", player_duration); end
    endtask

    task automatic test_done_same_edge();
        do_reset();
        play = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_note = 6'(20 + k); in_duration = 6'(2 * k + 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        note_done = 3'b001;
        tick();
        note_done = '0;
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL same_edge_nodisp: got %b want 000", player_new_note); end
        tests++; if (busy !== 3'b110) begin failed++; $display("FAIL same_edge_busy: got %b want 110", busy); end
        tick();
        tests++; if (player_new_note !== 3'b001) begin failed++; $display("FAIL same_edge_next: got %b want 001", player_new_note); end
        tests++; if (player_note !== 6'd23) begin failed++; $display("FAIL same_edge_note: got %0d want 23", player_note); end
    endtask

    task automatic test_overflow();
        logic [NP-1:0] exp_pnn [3];
        exp_pnn[0] = 3'b001; exp_pnn[1] = 3'b010; exp_pnn[2] = 3'b100;
        do_reset();
        play = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_note = 6'(30 + k); in_duration = 6'(40 + k);
            tick();
            if (k == 3) begin
                tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL ovf_full_ready: got %b want 0", in_ready); end
                tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
            end
        end
        in_valid = 1'b0;
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_set: got %b want 1", overflow); end
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL ovf_play_low: got %b want 000", player_new_note); end
        play = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (player_new_note !== exp_pnn[k] || player_note !== 6'(30 + k)) begin
                failed++; $display("FAIL ovf_drain%0d: got %b/%0d want %b/%0d", k, player_new_note, player_note, exp_pnn[k], 30 + k);
            end
        end
        tick();
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        note_done = 3'b100;
        tick();
        note_done = '0;
        tick();
        tests++; if (player_new_note !== 3'b100 || player_note !== 6'd33) begin
            failed++; $display("FAIL ovf_drain3: got %b/%0d want 100/33", player_new_note, player_note);
        end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL ovf_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_flush();
        do_reset();
        play = 1'b1; in_valid = 1'b1; in_note = 6'd40; in_duration = 6'd1;
        tick();
        in_valid = 1'b0;
        tick();
        play = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_note = 6'(41 + k); in_duration = 6'd2;
            tick();
        end
        play = 1'b1; flush = 1'b1; in_valid = 1'b1; in_note = 6'd43;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL flush_nodisp: got %b want 000", player_new_note); end
        tests++; if (busy !== 3'b001) begin failed++; $display("FAIL flush_busy: got %b want 001", busy); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL flush_ovf: got %b want 0", overflow); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL flush_empty%0d: got %b want 000", k, player_new_note); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        play = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_note = 6'(50 + k); in_duration = 6'd3;
            tick();
        end
        in_valid = 1'b0; play = 1'b1;
        tick();
        tick();
        tests++; if (busy !== 3'b011) begin failed++; $display("FAIL rstmid_pre_busy: got %b want 011", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy !== 3'b000) begin failed++; $display("FAIL rstmid_busy: got %b want 000", busy); end
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL rstmid_pnn: got %b want 000", player_new_note); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
        tick();
        tests++; if (player_new_note !== 3'b000) begin failed++; $display("FAIL rstmid_emptied: got %b want 000", player_new_note); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom % 600) == 0;
            play        = ($urandom % 8) != 0;
            flush       = ($urandom % 40) == 0;
            in_valid    = ($urandom % 3) != 0;
            in_note     = 6'($urandom);
            in_duration = 6'($urandom);
            for (int i = 0; i < NP; i++) note_done[i] = ($urandom % 4) == 0;
            tick();
            tests++;
            if (player_new_note !== m_pnn || busy !== m_busy || player_note !== m_note ||
                player_duration !== m_dur || overflow !== m_ovf || in_ready !== (m_q.size() < DEPTH)) begin
                failed++;
                $display("FAIL random_c%0d: got pnn=%b busy=%b note=%0d dur=%0d ovf=%b rdy=%b want pnn=%b busy=%b note=%0d dur=%0d ovf=%b rdy=%b",
                         c, player_new_note, busy, player_note, player_duration, overflow, in_ready,
                         m_pnn, m_busy, m_note, m_dur, m_ovf, (m_q.size() < DEPTH));
            end
        end
        reset = 1'b0; play = 1'b0; flush = 1'b0; in_valid = 1'b0; note_done = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_done_same_edge();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
